// File: rtl/x_rams64_fifo_ctl.sv
// x_rams64_fifo_ctl: 64x1 FIFO controller driving one single-port distributed RAM; RAMS64_FIFO_ALMOST_EN adds almost flags
module x_rams64_fifo_ctl
`ifdef RAMS64_FIFO_ALMOST_EN
#(
    parameter int AF_LEVEL = 60,
    parameter int AE_LEVEL = 4
)
`endif
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR_VALID,
    input  logic       WR_DATA,
    output logic       WR_READY,
    input  logic       RD_REQ,
    output logic       RD_ACK,
    output logic       DOUT,
    output logic       DOUT_VALID,
    output logic       FULL,
    output logic       EMPTY,
    output logic [6:0] COUNT,
    output logic [5:0] RAM_ADR,
    output logic       RAM_WE,
    output logic       RAM_I,
    input  logic       RAM_O
`ifdef RAMS64_FIFO_ALMOST_EN
    ,
    output logic       ALMOST_FULL,
    output logic       ALMOST_EMPTY
`endif
);
    logic [5:0] wptr, rptr;
    logic [6:0] cnt;
    logic       pri, we_ok, re_ok, wr_gnt, rd_gnt;

    // arbitration: a lone eligible side wins, a contested cycle goes to the PRI-favoured side; nothing is granted under reset
    always_comb begin
        we_ok    = WR_VALID & ~FULL & ~RST;
        re_ok    = RD_REQ & ~EMPTY & ~RST;
        wr_gnt   = we_ok & (~re_ok | ~pri);
        rd_gnt   = re_ok & (~we_ok | pri);
        WR_READY = wr_gnt;
        RD_ACK   = rd_gnt;
        RAM_WE   = wr_gnt;
        RAM_ADR  = wr_gnt ? wptr : rptr;
        RAM_I    = wr_gnt ? WR_DATA : 1'b0;
        FULL     = cnt == 7'd64;
        EMPTY    = cnt == 7'd0;
        COUNT    = cnt;
    end

`ifdef RAMS64_FIFO_ALMOST_EN
    // almost flags decoded from the registered occupancy
    always_comb begin
        ALMOST_FULL  = cnt >= 7'(AF_LEVEL);
        ALMOST_EMPTY = cnt <= 7'(AE_LEVEL);
    end
`endif

    // pointers, occupancy, fairness flag and registered read data
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr       <= '0;
            rptr       <= '0;
            cnt        <= '0;
            pri        <= 1'b0;
            DOUT       <= 1'b0;
            DOUT_VALID <= 1'b0;
        end else begin
            if (wr_gnt) wptr <= wptr + 6'd1;
            if (rd_gnt) rptr <= rptr + 6'd1;
            cnt <= cnt + {6'd0, wr_gnt} - {6'd0, rd_gnt};
            if (we_ok & re_ok) pri <= ~pri;
            if (rd_gnt) DOUT <= RAM_O;
            DOUT_VALID <= rd_gnt;
        end
    end
endmodule

// File: tb/tb_x_rams64_fifo_ctl.sv
// tb_x_rams64_fifo_ctl: queue-model bench with a 64x1 RAM model and directed scenarios
module tb_x_rams64_fifo_ctl;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       WR_VALID = 1'b0, WR_DATA = 1'b0, RD_REQ = 1'b0;
    logic       WR_READY, RD_ACK, DOUT, DOUT_VALID, FULL, EMPTY, RAM_WE, RAM_I, RAM_O;
    logic [6:0] COUNT;
    logic [5:0] RAM_ADR;
`ifdef RAMS64_FIFO_ALMOST_EN
    logic       ALMOST_FULL, ALMOST_EMPTY;
`endif

    int n_chk = 0, n_fail = 0;
    logic ram [64];
    logic last_wr, last_rd, last_we;
    logic [5:0] last_adr;

    x_rams64_fifo_ctl dut (
        .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
        .RD_REQ(RD_REQ), .RD_ACK(RD_ACK), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
        .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT), .RAM_ADR(RAM_ADR), .RAM_WE(RAM_WE),
        .RAM_I(RAM_I), .RAM_O(RAM_O)
`ifdef RAMS64_FIFO_ALMOST_EN
        , .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY)
`endif
    );

    always #5 CLK = ~CLK;

    initial for (int i = 0; i < 64; i++) ram[i] = 1'b0;
    always @(posedge CLK) if (RAM_WE) ram[RAM_ADR] <= RAM_I;
    assign RAM_O = ram[RAM_ADR];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // reference model: FIFO contents as a queue, access counts for addresses, favoured side for contention
    logic q[$];
    logic fav_rd = 1'b0, e_dout = 1'b0, e_dv = 1'b0;
    int   n_w = 0, n_r = 0;

    always @(negedge CLK) begin
        if (RST) begin
            q.delete();
            fav_rd = 1'b0; e_dout = 1'b0; e_dv = 1'b0; n_w = 0; n_r = 0;
            chk("rst_wr_ready", int'(WR_READY), 0);
            chk("rst_rd_ack", int'(RD_ACK), 0);
            chk("rst_ram_we", int'(RAM_WE), 0);
            chk("rst_ram_adr", int'(RAM_ADR), 0);
            chk("rst_ram_i", int'(RAM_I), 0);
            chk("rst_dout", int'(DOUT), 0);
            chk("rst_dout_valid", int'(DOUT_VALID), 0);
            chk("rst_count", int'(COUNT), 0);
            chk("rst_full", int'(FULL), 0);
            chk("rst_empty", int'(EMPTY), 1);
`ifdef RAMS64_FIFO_ALMOST_EN
            chk("rst_almost_full", int'(ALMOST_FULL), 0);
            chk("rst_almost_empty", int'(ALMOST_EMPTY), 1);
`endif
        end else begin
            automatic bit can_w = WR_VALID && q.size() < 64;
            automatic bit can_r = RD_REQ && q.size() > 0;
            automatic bit gw = can_w && !(can_r && fav_rd);
            automatic bit gr = can_r && !gw;
            chk("count", int'(COUNT), q.size());
            chk("full", int'(FULL), int'(q.size() == 64));
            chk("empty", int'(EMPTY), int'(q.size() == 0));
            chk("dout", int'(DOUT), int'(e_dout));
            chk("dout_valid", int'(DOUT_VALID), int'(e_dv));
`ifdef RAMS64_FIFO_ALMOST_EN
            chk("almost_full", int'(ALMOST_FULL), int'(q.size() >= 60));
            chk("almost_empty", int'(ALMOST_EMPTY), int'(q.size() <= 4));
`endif
            chk("wr_ready", int'(WR_READY), int'(gw));
            chk("rd_ack", int'(RD_ACK), int'(gr));
            chk("ram_we", int'(RAM_WE), int'(gw));
            chk("ram_adr", int'(RAM_ADR), gw ? n_w % 64 : n_r % 64);
            chk("ram_i", int'(RAM_I), gw ? int'(WR_DATA) : 0);
            if (can_w && can_r) fav_rd = !fav_rd;
            if (gw) begin q.push_back(WR_DATA); n_w++; end
            if (gr) begin e_dout = q.pop_front(); n_r++; end
            e_dv = gr;
        end
    end

    task automatic step(input logic wv, input logic wd, input logic rr);
        WR_VALID = wv; WR_DATA = wd; RD_REQ = rr;
        #1;
        last_wr = WR_READY; last_rd = RD_ACK; last_we = RAM_WE; last_adr = RAM_ADR;
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        WR_VALID = 1'b0; RD_REQ = 1'b0; WR_DATA = 1'b0;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    logic [3:0] wbits;
    logic [5:0] pat;
    logic       held;

    initial begin
        wbits = 4'b1101;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, wbits[i], 1'b0);
            chk("t1_wr_ready", int'(last_wr), 1);
            chk("t1_adr", int'(last_adr), i);
        end
        chk("t1_count4", int'(COUNT), 4);
        chk("t1_empty0", int'(EMPTY), 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("t1_rd_ack", int'(last_rd), 1);
            chk("t1_dout", int'(DOUT), int'(wbits[i]));
            chk("t1_dv", int'(DOUT_VALID), 1);
        end
        chk("t1_count0", int'(COUNT), 0);
        chk("t1_empty1", int'(EMPTY), 1);

        do_reset();
        for (int i = 0; i < 64; i++) step(1'b1, i[0], 1'b0);
        chk("t2_full", int'(FULL), 1);
        chk("t2_count64", int'(COUNT), 64);
        step(1'b1, 1'b1, 1'b0);
        chk("t2_wr_ready_full", int'(last_wr), 0);
        chk("t2_we_full", int'(last_we), 0);
        for (int i = 0; i < 64; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("t2_rd_adr", int'(last_adr), i);
            chk("t2_dout", int'(DOUT), int'(i[0]));
        end
        step(1'b1, 1'b1, 1'b0);
        chk("t2_wrap_adr", int'(last_adr), 0);

        do_reset();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b1);
            pat[i] = last_wr;
        end
        chk("t3_pattern", int'(pat), 6'b010101);
        chk("t3_count10", int'(COUNT), 10);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        held = DOUT;
        step(1'b0, 1'b0, 1'b1);
        chk("t4_rd_ack_empty", int'(last_rd), 0);
        chk("t4_dv_empty", int'(DOUT_VALID), 0);
        chk("t4_dout_held", int'(DOUT), int'(held));

        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, i[1], 1'b0);
        RST = 1'b1;
        #1;
        chk("t5_we_in_rst", int'(RAM_WE), 0);
        @(posedge CLK); #1;
        RST = 1'b0; WR_VALID = 1'b0;
        #1;
        chk("t5_count0", int'(COUNT), 0);
        chk("t5_empty1", int'(EMPTY), 1);
        step(1'b1, 1'b1, 1'b0);
        chk("t5_adr0", int'(last_adr), 0);

`ifdef RAMS64_FIFO_ALMOST_EN
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        chk("t6_ae_at4", int'(ALMOST_EMPTY), 1);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_ae_at5", int'(ALMOST_EMPTY), 0);
        for (int i = 5; i < 59; i++) step(1'b1, 1'b0, 1'b0);
        chk("t6_af_at59", int'(ALMOST_FULL), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_af_at60", int'(ALMOST_FULL), 1);
        step(1'b0, 1'b0, 1'b1);
        chk("t6_af_after_rd", int'(ALMOST_FULL), 0);
`endif

        step(1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/x_rams64_fifo_ctl.md
# x_rams64_fifo_ctl

Single-clock FIFO controller that turns one 64x1 single-port distributed RAM cell into a 64-deep, 1-bit FIFO. It sits directly upstream of the RAM: it drives the RAM's shared address, write-enable and data-in, and captures the RAM's asynchronous read output into a registered data port. Because the RAM has one address bus, the block arbitrates between write and read requests, granting at most one access per cycle.

## Interface
Parameters:
- AF_LEVEL, 60, ALMOST_FULL threshold on COUNT; used only with the macro.
- AE_LEVEL, 4, ALMOST_EMPTY threshold on COUNT; used only with the macro.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- WR_VALID  input  1  write request.
- WR_DATA  input  1  bit to write.
- WR_READY  output  1  write granted this cycle (combinational).
- RD_REQ  input  1  read request.
- RD_ACK  output  1  read granted this cycle (combinational).
- DOUT  output  1  registered read data.
- DOUT_VALID  output  1  one-cycle pulse; DOUT holds new data.
- FULL  output  1  COUNT == 64.
- EMPTY  output  1  COUNT == 0.
- COUNT  output  7  occupancy, 0..64.
- RAM_ADR  output  6  to RAM ADR5..ADR0.
- RAM_WE  output  1  to RAM WE.
- RAM_I  output  1  to RAM I.
- RAM_O  input  1  from RAM O, asynchronous read of RAM_ADR.
- ALMOST_FULL, ALMOST_EMPTY  output  1  present only with the macro.

## Operation
- State:
  - WPTR[5:0] and RPTR[5:0]: 6-bit pointers that wrap naturally at 63 -> 0.
  - CNT[6:0].
  - Priority flag PRI: 0 = write favoured, 1 = read favoured.
- Eligibility (combinational):
  - we_ok = WR_VALID & ~FULL.
  - re_ok = RD_REQ & ~EMPTY.
- Grant:
  - Only one eligible: that side wins.
  - Both eligible (contested): PRI picks the winner, and PRI toggles to favour the loser.
  - Uncontested cycles leave PRI unchanged.
- Write grant:
  - WR_READY=1, RAM_ADR=WPTR, RAM_WE=1, RAM_I=WR_DATA.
  - The RAM stores the bit at the edge.
  - WPTR+1, CNT+1.
- Read grant:
  - RD_ACK=1, RAM_ADR=RPTR, RAM_WE=0.
  - At the edge, DOUT <= RAM_O and DOUT_VALID <= 1.
  - RPTR+1, CNT-1.
- No grant:
  - RAM_ADR=RPTR, RAM_WE=0, RAM_I=0.
  - DOUT holds its value; DOUT_VALID <= 0.
- Boundary behaviour:
  - A write while FULL is never granted.
  - A read while EMPTY is never granted; RD_ACK=0 and no DOUT_VALID.
  - A read and a write can never both be granted in the same cycle, so CNT changes by at most ±1 per cycle.
  - Write-to-read turnaround: a bit written at edge N is readable from cycle N+1.
- Reset (asynchronous, also mid-operation):
  - WPTR=RPTR=0, CNT=0, PRI=0, DOUT=0, DOUT_VALID=0.
  - RAM_WE is forced to 0 while RST is high, regardless of requests.
  - RAM contents are not cleared; the FIFO is logically empty afterwards.
  - An access granted in the cycle RST asserts is lost.

## Timing
- Reset values: WR_READY=0, RD_ACK=0, DOUT=0, DOUT_VALID=0, FULL=0, EMPTY=1, COUNT=0, RAM_ADR=0, RAM_WE=0, RAM_I=0. With the macro: ALMOST_FULL=0, ALMOST_EMPTY=1.
- WR_READY, RD_ACK, RAM_ADR, RAM_WE and RAM_I are combinational from requests and registered state; there are no combinational paths from RAM_O.
- Read latency: DOUT/DOUT_VALID are valid one cycle after the RD_ACK cycle.
- Sustained throughput:
  - One access per cycle.
  - Under continuous contention, writes and reads alternate 1:1.
- FULL, EMPTY and COUNT are registered-derived and update the cycle after the grant edge.

## Configuration
- Macro RAMS64_FIFO_ALMOST_EN.
- Defined:
  - ALMOST_FULL = (COUNT >= AF_LEVEL).
  - ALMOST_EMPTY = (COUNT <= AE_LEVEL).
  - Both are decoded from the registered CNT.
- Undefined:
  - ALMOST_FULL and ALMOST_EMPTY ports and their logic are absent.
  - AF_LEVEL and AE_LEVEL are ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then write the bits 1,0,1,1 on 4 consecutive cycles -> WR_READY=1 each cycle, RAM_ADR=0..3, COUNT=4, EMPTY=0. Then read 4 times -> DOUT sequence 1,0,1,1, each one cycle after its RD_ACK, COUNT=0, EMPTY=1.
- Fill with 64 writes of the pattern ADR[0] -> FULL=1, COUNT=64. A 65th WR_VALID -> WR_READY=0, RAM_WE=0. Drain 64 reads -> 0,1,0,1,… pattern, with RAM_ADR wrapping 63 -> 0 on the next round.
- With COUNT=10, hold WR_VALID=1 and RD_REQ=1 for 6 cycles -> grants alternate W,R,W,R,W,R starting with write, COUNT ends at 10.
- RD_REQ=1 while EMPTY -> RD_ACK=0, DOUT_VALID=0, DOUT unchanged.
- Write 20 bits, assert RST for 1 cycle mid-stream with WR_VALID still high -> RAM_WE=0 during RST, COUNT=0, EMPTY=1, pointers 0. The next write targets RAM_ADR=0.
- With the macro, AF_LEVEL=60 and AE_LEVEL=4: write 5 -> ALMOST_EMPTY falls at COUNT=5. Write to 60 -> ALMOST_FULL rises at COUNT=60. One read -> ALMOST_FULL falls.
